// File: rtl/mem_stage_access_ctrl_if.sv
// Bus between the MEM-stage access controller and the variable-latency data memory.
interface mem_stage_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack handshake, pipeline stall, registered load data.
// Optional REQ wait timeout is compiled in with `define MEM_ACCESS_TIMEOUT_EN.
module mem_stage_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              memHAZ,
  output logic              misalign,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles,
  mem_stage_access_ctrl_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_nxt;

  logic access_c;
  logic aligned_c;
  logic start_c;
  logic ack_done_c;
  logic timeout_c;
  logic misalign_c;
  logic timeout_hit_c;

  assign access_c  = memRead | memWrite;
  assign aligned_c = (addr[1:0] == 2'b00);

  // A zero timeout would underflow the wait-counter compare value.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_c    = 1'b0;
    ack_done_c = 1'b0;
    timeout_c  = 1'b0;
    misalign_c = 1'b0;
    memHAZ     = 1'b0;
    case (state)
      IDLE: begin
        if (access_c) begin
          if (aligned_c) begin
            start_c   = 1'b1;
            memHAZ    = 1'b1;
            state_nxt = REQ;
          end else begin
            misalign_c = 1'b1;
          end
        end
      end
      REQ: begin
        memHAZ = 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (mem.mem_ack) begin
          ack_done_c = 1'b1;
          state_nxt  = DONE;
        end else if (timeout_hit_c) begin
          timeout_c = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields, load data, misalign pulse and stall counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rdata         <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      misalign      <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      misalign <= misalign_c;
      if (start_c) begin
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= memWrite;
        mem.mem_addr  <= addr;
        mem.mem_wdata <= wdata;
      end
      if (ack_done_c || timeout_c) mem.mem_req <= 1'b0;
      if (ack_done_c && !mem.mem_we) rdata <= mem.mem_rdata;
      if (timeout_c && !mem.mem_we)  rdata <= DATA_W'(32'hDEADBEEF);
      if (memHAZ && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign timeout_hit_c = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // Counts REQ cycles without ack; cleared as each request is launched.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      mem_err <= timeout_c;
      if (start_c)
        wait_cnt <= '0;
      else if ((state == REQ) && !mem.mem_ack)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign timeout_hit_c = 1'b0;
  assign mem_err       = 1'b0;
`endif

endmodule
